// File: rtl/cpu_pkg.sv
// Shared definitions for the 33-bit CPU control path: opcodes, FSM states,
// ALU operation codes and the instruction width.
package cpu_pkg;

  localparam int unsigned INSTR_W = 33;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_LD   = 5'h01;
  localparam logic [4:0] OP_LI   = 5'h02;
  localparam logic [4:0] OP_ST   = 5'h03;
  localparam logic [4:0] OP_ADD  = 5'h05;
  localparam logic [4:0] OP_ADDI = 5'h06;
  localparam logic [4:0] OP_BNE  = 5'h0E;
  localparam logic [4:0] OP_HALT = 5'h1F;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_PASS_B = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALTED,
    S_FAULT
  } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable down-counter bounding how long the sequencer waits for an
// imem/dmem acknowledge. expired is high once LOAD_VAL counting cycles
// have elapsed since the last load.
module mem_wait_timer #(
  parameter int unsigned LOAD_VAL = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (LOAD_VAL < 2) ? 1 : $clog2(LOAD_VAL + 1);

  logic [CNT_W-1:0] cnt;

  // Reload on reset or wait-state entry, otherwise count down and hold at zero
  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= CNT_W'(LOAD_VAL);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: fetch, decode settle, execute, memory, writeback.
// Optional build macro PERF_CNT_EN adds cycle/retired-instruction counters.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned MEM_TO = 15
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  input  logic [4:0]         opcode,
  input  logic [3:0]         reg_dest,
  input  logic [15:0]        immediate,
  output logic [1:0]         alu_op,
  output logic               alu_bsel,
  input  logic               alu_zero,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic               rf_we,
  output logic               rf_wsel,
  output logic               halted,
  output logic               fault
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]        cyc_cnt,
  output logic [31:0]        ret_cnt
`endif
);

  state_t          state, state_next;
  logic [PC_W-1:0] pc, pc_next, pc_inc, br_off;
  logic            tmr_load, tmr_en, tmr_expired;
  logic            unused_fields;

  // Sources are read by the regfile directly; only the branch offset low bits matter here
  assign unused_fields = ^{reg_dest, immediate};

  assign pc_inc    = pc + PC_W'(1);
  assign br_off    = PC_W'($signed(immediate));
  assign imem_addr = pc;

  // Every state change restarts the wait budget; only FETCH and MEM consume it
  assign tmr_load = (state_next != state);
  assign tmr_en   = (state == S_FETCH) || (state == S_MEM);

  mem_wait_timer #(
    .LOAD_VAL (MEM_TO - 1)
  ) u_wait (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // PC and instruction latch
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      instruction <= '0;
    end else begin
      pc <= pc_next;
      if ((state == S_FETCH) && imem_ack) begin
        instruction <= imem_rdata;
      end
    end
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH: begin
        if (imem_ack)         state_next = S_DECODE;
        else if (tmr_expired) state_next = S_FAULT;
      end
      S_DECODE: state_next = S_EXECUTE;
      S_EXECUTE: begin
        case (opcode)
          OP_LD, OP_ST:          state_next = S_MEM;
          OP_NOP, OP_BNE:        state_next = S_FETCH;
          OP_LI, OP_ADD, OP_ADDI: state_next = S_WB;
          OP_HALT:               state_next = S_HALTED;
          default:               state_next = S_FAULT;
        endcase
      end
      S_MEM: begin
        if (dmem_ack)         state_next = (opcode == OP_LD) ? S_WB : S_FETCH;
        else if (tmr_expired) state_next = S_FAULT;
      end
      S_WB:     state_next = S_FETCH;
      S_HALTED: state_next = S_HALTED;
      S_FAULT:  state_next = S_FAULT;
      default:  state_next = S_FAULT;
    endcase
  end

  // PC advance: sequential on retirement, branch target on taken BNE
  always_comb begin
    pc_next = pc;
    case (state)
      S_EXECUTE: begin
        if (opcode == OP_NOP) begin
          pc_next = pc_inc;
        end else if (opcode == OP_BNE) begin
          pc_next = alu_zero ? pc_inc : pc_inc + br_off;
        end
      end
      S_MEM: begin
        if (dmem_ack && (opcode == OP_ST)) pc_next = pc_inc;
      end
      S_WB:    pc_next = pc_inc;
      default: pc_next = pc;
    endcase
  end

  // Strobes and datapath controls
  always_comb begin
    imem_req = (state == S_FETCH);
    dmem_req = (state == S_MEM);
    dmem_we  = (state == S_MEM) && (opcode == OP_ST);
    rf_we    = (state == S_WB);
    rf_wsel  = (state == S_WB) && (opcode == OP_LD);
    halted   = (state == S_HALTED);
    fault    = (state == S_FAULT);
    alu_op   = ALU_ADD;
    alu_bsel = 1'b0;
    if ((state == S_EXECUTE) || (state == S_MEM) || (state == S_WB)) begin
      case (opcode)
        OP_LD, OP_ST, OP_LI: begin
          alu_op   = ALU_PASS_B;
          alu_bsel = 1'b1;
        end
        OP_ADDI: alu_bsel = 1'b1;
        OP_BNE:  alu_op   = ALU_SUB;
        default: alu_op   = ALU_ADD;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic retire;

  assign retire = ((state == S_EXECUTE) || (state == S_MEM) || (state == S_WB)) &&
                  ((state_next == S_FETCH) || (state_next == S_HALTED));

  // Saturating cycle and retirement counters; cycle count freezes once halted
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if ((state != S_HALTED) && (cyc_cnt != '1)) cyc_cnt <= cyc_cnt + 32'd1;
      if (retire && (ret_cnt != '1))              ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a small regfile/ALU/memory model.
module tb_control_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [32:0] imem_rdata = '0;
  logic [32:0] instruction;
  logic [4:0]  opcode;
  logic [3:0]  reg_dest;
  logic [15:0] immediate;
  logic [1:0]  alu_op;
  logic        alu_bsel;
  logic        alu_zero;
  logic        dmem_req, dmem_we;
  logic        dmem_ack = 1'b0;
  logic        rf_we, rf_wsel, halted, fault;
`ifdef PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  logic [32:0] prog [256];
  logic [31:0] rf   [16];
  logic [31:0] dmem [256];
  int          fetch_cnt [256];
  logic        imem_en = 1'b1;
  logic        dmem_en = 1'b1;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_rfwe, n_ld, n_st;
  logic [3:0]  src1, src2;
  logic [31:0] op_a, op_b, alu_y;

  always #5 clk = ~clk;

  control_sequencer #(.PC_W(8), .MEM_TO(15)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .opcode(opcode), .reg_dest(reg_dest), .immediate(immediate),
    .alu_op(alu_op), .alu_bsel(alu_bsel), .alu_zero(alu_zero),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .halted(halted), .fault(fault)
`ifdef PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  // Decoder model
  assign opcode    = instruction[32:28];
  assign reg_dest  = instruction[27:24];
  assign src1      = instruction[23:20];
  assign src2      = instruction[19:16];
  assign immediate = instruction[15:0];

  // ALU model
  always_comb begin
    op_a = rf[src1];
    op_b = alu_bsel ? {{16{immediate[15]}}, immediate} : rf[src2];
    case (alu_op)
      2'd0:    alu_y = op_a + op_b;
      2'd1:    alu_y = op_a - op_b;
      default: alu_y = op_b;
    endcase
  end
  assign alu_zero = (alu_y == 32'd0);

  // Memory responders: ack in the same cycle as the request when enabled
  always @(negedge clk) begin
    imem_ack   <= imem_req & imem_en;
    imem_rdata <= prog[imem_addr];
    dmem_ack   <= dmem_req & dmem_en;
  end

  // Regfile/dmem model and event counters, cleared while reset is held
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
      for (int i = 0; i < 256; i++) begin
        dmem[i]      <= 32'd0;
        fetch_cnt[i] <= 0;
      end
      dmem[8'h10] <= 32'd7;
      dmem[8'h20] <= 32'd5;
      n_rfwe <= 0;
      n_ld   <= 0;
      n_st   <= 0;
    end else begin
      if (rf_we) begin
        n_rfwe <= n_rfwe + 1;
        rf[reg_dest] <= rf_wsel ? dmem[alu_y[7:0]] : alu_y;
      end
      if (dmem_req && dmem_ack) begin
        if (dmem_we) begin
          n_st <= n_st + 1;
          dmem[alu_y[7:0]] <= rf[src1];
        end else begin
          n_ld <= n_ld + 1;
        end
      end
      if (imem_req && imem_ack) fetch_cnt[imem_addr] <= fetch_cnt[imem_addr] + 1;
    end
  end

  function automatic logic [32:0] enc(input logic [4:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) prog[i] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'h0000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // ---- Load/add/store program, then HALT ----
    fill_halt();
    prog[0] = enc(OP_LD,  4'd1, 4'd0, 4'd0, 16'h0010);
    prog[1] = enc(OP_LD,  4'd2, 4'd0, 4'd0, 16'h0020);
    prog[2] = enc(OP_ADD, 4'd2, 4'd2, 4'd1, 16'h0000);
    prog[3] = enc(OP_ST,  4'd0, 4'd2, 4'd0, 16'h0030);
    do_reset();
    chk("rst_imem_req", imem_req, 1);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_instruction", instruction, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_wsel", rf_wsel, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_bsel", alu_bsel, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    cycles(17);
    chk("st_mem_dmem_req", dmem_req, 1);
    chk("st_mem_dmem_we", dmem_we, 1);
    chk("st_mem_imem_req", imem_req, 0);
    chk("st_mem_pc", imem_addr, 3);
    cycles(1);
    chk("prog_pc_cycle19", imem_addr, 4);
    chk("prog_fetch_cycle19", imem_req, 1);
    chk("prog_loads", n_ld, 2);
    chk("prog_stores", n_st, 1);
    chk("prog_rf_we_count", n_rfwe, 3);
    chk("prog_store_data", dmem[8'h30], 12);
    cycles(3);
    chk("halt_halted", halted, 1);
    chk("halt_imem_req", imem_req, 0);
`ifdef PERF_CNT_EN
    chk("perf_ret_cnt", ret_cnt, 5);
    chk("perf_cyc_cnt", cyc_cnt, 21);
`endif
    cycles(5);
    chk("halt_sticky", halted, 1);
    chk("halt_rf_we_count", n_rfwe, 3);
`ifdef PERF_CNT_EN
    chk("perf_cyc_frozen", cyc_cnt, 21);
`endif

    // ---- Counted loop with backward branch ----
    fill_halt();
    prog[0] = enc(OP_LI,   4'd1, 4'd0, 4'd0, 16'h0000);
    prog[1] = enc(OP_LI,   4'd2, 4'd0, 4'd0, 16'h0000);
    prog[2] = enc(OP_LI,   4'd3, 4'd0, 4'd0, 16'h000A);
    prog[3] = enc(OP_ADD,  4'd2, 4'd2, 4'd1, 16'h0000);
    prog[4] = enc(OP_ADDI, 4'd1, 4'd1, 4'd0, 16'h0001);
    prog[5] = enc(OP_BNE,  4'd3, 4'd1, 4'd3, 16'hFFFD);
    do_reset();
    chk("rst2_instruction", instruction, 0);
    for (int i = 0; i < 1000 && !halted; i++) @(negedge clk);
    chk("loop_halted", halted, 1);
    chk("loop_fetch_pc3", fetch_cnt[3], 10);
    chk("loop_fetch_pc5", fetch_cnt[5], 10);
    chk("loop_fetch_pc6", fetch_cnt[6], 1);
    chk("loop_r1", rf[1], 10);
    chk("loop_r2_sum", rf[2], 45);

    // ---- Branch target wraps below zero ----
    fill_halt();
    prog[0]     = enc(OP_LI,  4'd1, 4'd0, 4'd0, 16'h0001);
    prog[1]     = enc(OP_BNE, 4'd0, 4'd1, 4'd0, 16'hFFFD);
    prog[8'hFF] = enc(OP_NOP, 4'd0, 4'd0, 4'd0, 16'h0000);
    do_reset();
    cycles(7);
    chk("wrap_branch_target", imem_addr, 8'hFF);
    cycles(3);
    chk("wrap_pc_increment", imem_addr, 8'h00);

    // ---- Unknown opcode ----
    fill_halt();
    prog[0] = enc(5'h0A, 4'd1, 4'd0, 4'd0, 16'h0010);
    do_reset();
    cycles(3);
    chk("badop_fault", fault, 1);
    chk("badop_imem_req", imem_req, 0);
    cycles(5);
    chk("badop_fault_sticky", fault, 1);
    chk("badop_no_rf_we", n_rfwe, 0);
    chk("badop_no_dmem", n_ld + n_st, 0);

    // ---- dmem timeout ----
    fill_halt();
    prog[0] = enc(OP_LD, 4'd1, 4'd0, 4'd0, 16'h0010);
    dmem_en = 1'b0;
    do_reset();
    cycles(17);
    chk("to_wait_dmem_req", dmem_req, 1);
    chk("to_wait_no_fault", fault, 0);
    cycles(1);
    chk("to_fault", fault, 1);
    chk("to_dmem_req_drop", dmem_req, 0);
    chk("to_no_rf_we", n_rfwe, 0);

    // ---- Reset in the middle of a data access ----
    fill_halt();
    prog[0] = enc(OP_NOP, 4'd0, 4'd0, 4'd0, 16'h0000);
    prog[1] = enc(OP_LD,  4'd1, 4'd0, 4'd0, 16'h0010);
    do_reset();
    cycles(8);
    chk("mid_mem_dmem_req", dmem_req, 1);
    chk("mid_mem_pc", imem_addr, 1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("mid_rst_pc", imem_addr, 0);
    chk("mid_rst_imem_req", imem_req, 1);
    chk("mid_rst_dmem_req", dmem_req, 0);
    chk("mid_rst_instruction", instruction, 0);
    dmem_en = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
